// File: rtl/mul_seq.sv
// -----------------------------------------------------------------------------
// mul_seq
//
// Iterative unsigned XLEN x XLEN -> 2*XLEN multiplier for the EX stage
// (MUL / MULHU). One shared adder performs a single shift-and-add step per
// clock, so every product takes exactly XLEN steps in BUSY whatever the
// operands are. There is no early-out.
//
// A small IDLE / BUSY / DONE state machine sequences the work. Both sides use
// a valid/ready handshake. A flush input lets the pipeline kill an op at any
// time, and the killed result is never presented.
//
// Ports
//   clk        in   1     clock; all state changes on the rising edge
//   rst        in   1     synchronous active-high reset (highest priority)
//   flush      in   1     abort current op, return to IDLE next edge
//   in_valid   in   1     operands valid
//   in_ready   out  1     operands can be accepted (high only in IDLE)
//   in_a       in   XLEN  multiplicand, sampled only on accept
//   in_b       in   XLEN  multiplier, sampled only on accept
//   out_valid  out  1     product valid (high only in DONE)
//   out_ready  in   1     consumer takes the product
//   out_lo     out  XLEN  product[XLEN-1:0]
//   out_hi     out  XLEN  product[2*XLEN-1:XLEN]
//
// All outputs come straight from flops. out_lo and out_hi mirror the
// accumulator, so they are deterministic (never X) in every state, even where
// consumers must ignore them.
// -----------------------------------------------------------------------------
module mul_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_lo,
  output logic [XLEN-1:0] out_hi
);

  // The counter must be able to represent XLEN-1. The extra bit keeps the
  // width legal for any XLEN >= 1.
  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [XLEN-1:0]  WORD_ZERO = {XLEN{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic [CNT_W-1:0] count_r;
  logic [XLEN-1:0]  mcand_r;
  logic [XLEN-1:0]  acc_hi_r;
  logic [XLEN-1:0]  acc_lo_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             accept_s;
  logic             step_s;
  logic [XLEN:0]    sum_s;

  // One shift-and-add step. The partial product is added to the high half at
  // XLEN+1 bits, so the carry out of the add is kept rather than lost.
  function automatic logic [XLEN:0] step_sum(
    input logic [XLEN-1:0] hi,
    input logic [XLEN-1:0] mc,
    input logic            mbit
  );
    logic [XLEN:0] addend;
    if (mbit) begin
      addend = {1'b0, mc};
    end else begin
      addend = {(XLEN+1){1'b0}};
    end
    return {1'b0, hi} + addend;
  endfunction

  // Adder: the current multiplier LSB selects whether mcand is added.
  always_comb begin
    sum_s = step_sum(acc_hi_r, mcand_r, acc_lo_r[0]);
  end

  // Next-state and control strobes. flush overrides every handshake.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    step_s       = 1'b0;
    if (flush) begin
      next_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // in_ready is high throughout IDLE, so in_valid alone completes
          // the handshake.
          if (in_valid) begin
            accept_s     = 1'b1;
            next_state_s = ST_BUSY;
          end else begin
            next_state_s = ST_IDLE;
          end
        end
        ST_BUSY: begin
          step_s = 1'b1;
          if (count_r == LAST_CNT) begin
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_BUSY;
          end
        end
        ST_DONE: begin
          // No accept here: a new op can start only after the drain edge.
          if (out_ready) begin
            next_state_s = ST_IDLE;
          end else begin
            next_state_s = ST_DONE;
          end
        end
        default: begin
          next_state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State register and registered handshake flags, derived from the next
  // state so that they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      in_ready_r  <= (next_state_s == ST_IDLE);
      out_valid_r <= (next_state_s == ST_DONE);
    end
  end

  // Datapath: load on accept, shift-and-add while BUSY, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r  <= CNT_ZERO;
      mcand_r  <= WORD_ZERO;
      acc_hi_r <= WORD_ZERO;
      acc_lo_r <= WORD_ZERO;
    end else if (flush) begin
      count_r <= CNT_ZERO;
    end else if (accept_s) begin
      count_r  <= CNT_ZERO;
      mcand_r  <= in_a;
      acc_hi_r <= WORD_ZERO;
      acc_lo_r <= in_b;
    end else if (step_s) begin
      // The XLEN+1-bit sum fills the top of {acc_hi, acc_lo}. The consumed
      // multiplier bit falls off the bottom, and the product's low bits
      // build up from the top of acc_lo.
      acc_hi_r <= sum_s[XLEN:1];
      acc_lo_r <= {sum_s[0], acc_lo_r[XLEN-1:1]};
      count_r  <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_hi    = acc_hi_r;
  assign out_lo    = acc_lo_r;

endmodule

// File: tb/tb_mul_seq.sv
// Testbench for mul_seq. The reference is a plain 64-bit multiply. Inputs
// are driven and outputs sampled on the falling clock edge.
module tb_mul_seq;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_lo;
  logic [XLEN-1:0] out_hi;

  int checks;
  int errors;

  mul_seq #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_lo    (out_lo),
    .out_hi    (out_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wa;
    logic [63:0] wb;
    wa = {32'd0, a};
    wb = {32'd0, b};
    return wa * wb;
  endfunction

  // Waits (bounded) for in_ready, then performs one accept. It returns at the
  // falling edge just after the accepting rising edge. The operand inputs are
  // then scrambled, so any late sampling by the design would corrupt the result.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_a = $urandom;
    in_b = $urandom;
  endtask

  // Counts rising edges after the accept until out_valid. Returns -1 on timeout.
  task automatic wait_result(output logic [63:0] prod, output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    prod = {out_hi, out_lo};
    if (!out_valid) lat = -1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_flags: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    checks++;
    if ({out_hi, out_lo} !== 64'd0) begin
      errors++;
      $display("FAIL reset_out: got %h, want 0", {out_hi, out_lo});
    end
  endtask

  task automatic test_basic();
    logic [63:0] p;
    int lat;
    issue(32'd3, 32'd5);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_ready: got %b, want 0", in_ready);
    end
    wait_result(p, lat);
    checks++;
    if (lat !== XLEN) begin
      errors++;
      $display("FAIL basic_latency: got %0d, want %0d", lat, XLEN);
    end
    checks++;
    if (p !== 64'h00000000_0000000F) begin
      errors++;
      $display("FAIL basic_product: got %h, want 000000000000000f", p);
    end
    drain();
  endtask

  task automatic test_max();
    logic [63:0] p;
    int lat;
    issue(32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_result(p, lat);
    checks++;
    if (p !== 64'hFFFFFFFE_00000001 || lat !== XLEN) begin
      errors++;
      $display("FAIL max_product: got %h lat %0d, want fffffffe00000001 lat %0d", p, lat, XLEN);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [63:0] p;
    logic [63:0] exp;
    int lat;
    int bad;
    exp = ref_mul(32'hDEADBEEF, 32'h00C0FFEE);
    issue(32'hDEADBEEF, 32'h00C0FFEE);
    wait_result(p, lat);
    bad = 0;
    // An offered op during DONE must be ignored.
    in_valid = 1'b1;
    in_a = 32'd9;
    in_b = 32'd9;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out_hi, out_lo} !== exp) bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad !== 0 || p !== exp) begin
      errors++;
      $display("FAIL backpressure_hold: %0d bad cycles, got %h, want %h", bad, {out_hi, out_lo}, exp);
    end
    drain();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL backpressure_release: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] p;
    int lat;
    issue(32'h12345678, 32'h9ABCDEF0);
    wait_result(p, lat);
    checks++;
    if (p !== 64'h0B00EA4E_242D2080 || p !== ref_mul(32'h12345678, 32'h9ABCDEF0)) begin
      errors++;
      $display("FAIL b2b_first: got %h, want 0b00ea4e242d2080", p);
    end
    drain();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_after_drain: got %b, want 1", in_ready);
    end
    issue(32'd7, 32'd0);
    wait_result(p, lat);
    checks++;
    if (p !== 64'd0 || lat !== XLEN) begin
      errors++;
      $display("FAIL b2b_second: got %h lat %0d, want 0 lat %0d", p, lat, XLEN);
    end
    drain();
  endtask

  task automatic test_flush();
    logic [63:0] p;
    int lat;
    int rose;
    issue(32'hCAFEF00D, 32'h87654321);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL flush_idle: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    rose = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) rose++;
    end
    checks++;
    if (rose !== 0) begin
      errors++;
      $display("FAIL flush_no_valid: out_valid high %0d cycles, want 0", rose);
    end
    // flush together with in_valid in IDLE must not accept the op.
    flush = 1'b1;
    in_valid = 1'b1;
    in_a = 32'd5;
    in_b = 32'd5;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_blocks_accept: got in_ready=%b, want 1", in_ready);
    end
    issue(32'd2, 32'd2);
    wait_result(p, lat);
    checks++;
    if (p !== 64'd4 || lat !== XLEN) begin
      errors++;
      $display("FAIL flush_then_op: got %h lat %0d, want 4 lat %0d", p, lat, XLEN);
    end
    drain();
  endtask

  task automatic test_reset_mid_op();
    logic [63:0] p;
    int lat;
    issue(32'hFFFF0000, 32'h0000FFFF);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== 2'b10 || {out_hi, out_lo} !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid_op: got rdy=%b vld=%b out=%h, want 1 0 0", in_ready, out_valid, {out_hi, out_lo});
    end
    issue(32'd6, 32'd7);
    wait_result(p, lat);
    checks++;
    if (p !== 64'd42) begin
      errors++;
      $display("FAIL reset_then_op: got %h, want 42", p);
    end
    drain();
  endtask

  task automatic test_random();
    logic [63:0] p;
    logic [63:0] exp;
    logic [31:0] a;
    logic [31:0] b;
    int lat;
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = $urandom;
      if (i == 0) a = 32'd0;
      if (i == 1) b = 32'h80000000;
      exp = ref_mul(a, b);
      issue(a, b);
      wait_result(p, lat);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checks++;
      if (p !== exp || lat !== XLEN || {out_hi, out_lo} !== exp) begin
        errors++;
        $display("FAIL random_%0d: %h*%h got %h lat %0d, want %h lat %0d", i, a, b, {out_hi, out_lo}, lat, exp, XLEN);
      end
      drain();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_a = 32'd0;
    in_b = 32'd0;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_max();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid_op();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
